// File: rtl/lookup3_hash_pipe.sv
// Fully pipelined Bob Jenkins lookup3 hashword() engine: one key per cycle,
// NUM_HASH seeded lanes sharing one valid/ready pipeline with a sideband tag.
module lookup3_hash_pipe #(
   parameter int KEY_WORDS = 3,
   parameter int NUM_HASH  = 1,
   parameter int TAG_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [32*KEY_WORDS-1:0] key_in,
   input  logic [32*NUM_HASH-1:0]  seed_in,
   input  logic [TAG_W-1:0]        tag_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [32*NUM_HASH-1:0]  hash_out,
   output logic [TAG_W-1:0]        tag_out
);
   localparam int NB   = (KEY_WORDS + 2) / 3;
   localparam int NMIX = 6 * (NB - 1);
   localparam int NS   = NMIX + 8;
   localparam int KP   = 96 * NB;
   localparam logic [31:0] INIT = 32'hdeadbeef + 32'(KEY_WORDS << 2);

   typedef logic [31:0] word_t;

   function automatic word_t rotl(input word_t x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic word_t kword(input logic [KP-1:0] k, input int i);
      return k[32*i +: 32];
   endfunction

   // Stage s (1..NS-1) is one mix step, optionally followed by the next
   // block add, or one final step. The key is zero padded to whole blocks
   // so absent words of the last block add nothing.
   function automatic logic [95:0] step(input logic [95:0] v, input logic [KP-1:0] k,
                                        input int s);
      word_t a, b, c;
      int    j;
      {a, b, c} = v;
      if (s <= NMIX) begin
         j = (s - 1) / 6;
         case ((s - 1) % 6)
            0: begin a -= c; a ^= rotl(c, 4);  c += b; end
            1: begin b -= a; b ^= rotl(a, 6);  a += c; end
            2: begin c -= b; c ^= rotl(b, 8);  b += a; end
            3: begin a -= c; a ^= rotl(c, 16); c += b; end
            4: begin b -= a; b ^= rotl(a, 19); a += c; end
            default: begin
               c -= b; c ^= rotl(b, 4); b += a;
               a += kword(k, 3*j + 3);
               b += kword(k, 3*j + 4);
               c += kword(k, 3*j + 5);
            end
         endcase
      end else begin
         case (s - NMIX - 1)
            0: c = (c ^ b) - rotl(b, 14);
            1: a = (a ^ c) - rotl(c, 11);
            2: b = (b ^ a) - rotl(a, 25);
            3: c = (c ^ b) - rotl(b, 16);
            4: a = (a ^ c) - rotl(c, 4);
            5: b = (b ^ a) - rotl(a, 14);
            default: c = (c ^ b) - rotl(b, 24);
         endcase
      end
      return {a, b, c};
   endfunction

   logic [NS-1:0]                   vld;
   logic [NS-1:0]                   load;
   logic [KP-1:0]                   key_pad;
   logic [KP-1:0]                   key_q [NS];
   logic [TAG_W-1:0]                tag_q [NS];
   logic [NUM_HASH-1:0][95:0]       st_q  [NS];
   logic [NUM_HASH-1:0][95:0]       st_nx [NS];

   // A stage loads when empty or when its successor is loading; this
   // collapses bubbles while the output is stalled.
   always_comb begin
      load = '0;
      load[NS-1] = ~vld[NS-1] | out_ready;
      for (int s = NS - 2; s >= 0; s--)
         load[s] = ~vld[s] | load[s+1];
   end

   always_comb begin
      key_pad = '0;
      key_pad[32*KEY_WORDS-1:0] = key_in;
   end

   always_comb begin
      for (int s = 0; s < NS; s++)
         st_nx[s] = '0;
      for (int h = 0; h < NUM_HASH; h++)
         st_nx[0][h] = {INIT + seed_in[32*h +: 32] + kword(key_pad, 0),
                        INIT + seed_in[32*h +: 32] + kword(key_pad, 1),
                        INIT + seed_in[32*h +: 32] + kword(key_pad, 2)};
      for (int s = 1; s < NS; s++)
         for (int h = 0; h < NUM_HASH; h++)
            st_nx[s][h] = step(st_q[s-1][h], key_q[s-1], s);
   end

   always_ff @(posedge clk) begin
      if (load[0]) begin
         key_q[0] <= key_pad;
         tag_q[0] <= tag_in;
      end
      for (int s = 1; s < NS; s++) begin
         if (load[s]) begin
            key_q[s] <= key_q[s-1];
            tag_q[s] <= tag_q[s-1];
         end
      end
      for (int s = 0; s < NS; s++) begin
         if (load[s])
            st_q[s] <= st_nx[s];
      end
      if (rst) begin
         vld         <= '0;
         tag_q[NS-1] <= '0;
         st_q[NS-1]  <= '0;
      end else begin
         if (load[0])
            vld[0] <= in_valid;
         for (int s = 1; s < NS; s++) begin
            if (load[s])
               vld[s] <= vld[s-1];
         end
      end
   end

   assign in_ready  = load[0] & ~rst;
   assign out_valid = vld[NS-1];
   assign tag_out   = tag_q[NS-1];

   always_comb begin
      hash_out = '0;
      for (int h = 0; h < NUM_HASH; h++)
         hash_out[32*h +: 32] = st_q[NS-1][h][31:0];
   end

endmodule
